iter_alu: RTL and testbench
===========================

Name: iter_alu

Overview:
- Parametrised, clocked successor to the combinational 8-bit ALU.
- Accepts one operation per valid/ready handshake and computes it.
- Single-cycle logic/arithmetic ops complete in one cycle; multi-bit shifts, rotates and unsigned multiply run iteratively, one bit per cycle.
- Sits between the register file read port and the writeback/flag logic of the wider datapath.

Parameters:
- WIDTH, 8, operand/result width; power of two, >= 4.
- SHW, $clog2(WIDTH), shift-count width (derived; not overridden).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  block can accept an operation.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; for shift/rotate ops, count = b[SHW-1:0].
- op  in  4  operation code (see Behaviour).
- cin  in  1  carry in.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- q  out  WIDTH  result.
- cout  out  1  carry/flag out.
- z  out  1  q == 0.

Behaviour:
- Reset (synchronous, rst high at posedge):
  - state IDLE, out_valid=0, q=0, cout=0, z=1, in_ready=1.
  - Any in-flight op is abandoned; no result is produced for it.
- States and transitions:
  - IDLE -> BUSY, or IDLE -> DONE for single-cycle ops.
  - BUSY -> DONE.
  - DONE -> IDLE when out_ready.
  - in_ready = (state == IDLE) and is combinational from state.
- Accept:
  - An op is accepted on the posedge where in_valid & in_ready; call that edge T.
  - a, b, op and cin are captured at T; later changes are ignored until the next accept.
- Op encoding:
  - 0 AND, 1 OR, 2 XOR, 3 NOT a: cout=0.
  - 4 ADD: a+b, cout=carry.
  - 5 ADC: a+b+cin.
  - 6 SUB: a+~b+1, cout=1 means no borrow.
  - 7 SBC: a+~b+cin.
  - 8 SHL, 9 SHR logical, 10 SAR (sign-fill), 11 ROL (rotate left, not through carry).
  - 12 MULL: low WIDTH bits of unsigned a*b, cout=1 iff high half != 0.
  - 13 MULH: high WIDTH bits of unsigned a*b, cout=0.
  - 14, 15 reserved: q=0, cout=0, single-cycle.
- Latency (out_valid first high after edge):
  - Ops 0-7 and 14-15: T+1.
  - Shift/rotate with count n: T+1+n. n=0 gives q=a, cout=cin at T+1.
  - Counts wrap modulo WIDTH (WIDTH=8: count 9 behaves as 1).
  - MULL/MULH: T+1+WIDTH, shift-add, one partial product per cycle, 2*WIDTH-bit accumulator.
- Shift carry:
  - cout = last bit shifted or rotated out.
  - Intermediate per-bit values are internal only.
- Outputs in DONE:
  - q, cout and z are registered and held stable while out_valid=1 && !out_ready.
  - out_valid drops on the edge after out_ready is seen high.
  - q, cout and z hold their last values after the handshake.
- No accept in DONE, even if out_ready=1 in the same cycle; maximum throughput is one op per 2 cycles.
- z is always derived from the registered q.

Test Plan (WIDTH=8):
- ADD a=0xF0, b=0x20, cin=1 -> q=0x10, cout=1, z=0, out_valid at T+1. ADC with the same operands -> q=0x11, cout=1.
- SUB a=0x05, b=0x07 -> q=0xFE, cout=0. SBC a=0x05, b=0x05, cin=0 -> q=0xFF, cout=0. SUB a=b=0x33 -> q=0x00, z=1, cout=1.
- Shifts:
  - SHR a=0x81, b=3 -> q=0x10, cout=0, out_valid at T+4.
  - SAR a=0x80, b=2 -> q=0xE0, cout=0.
  - ROL a=0x81, b=1 -> q=0x03, cout=1.
  - SHL a=0x5A, b=0, cin=1 -> q=0x5A, cout=1 at T+1.
  - SHL b=9 equals SHL b=1.
- Multiply a=0x12, b=0x34 (product 0x03A8): MULL -> q=0xA8, cout=1, out_valid at T+9. MULH -> q=0x03, cout=0. MULL 0xFF*0x01 -> q=0xFF, cout=0.
- Backpressure: hold out_ready=0 for 5 cycles after the result -> q/cout stable, in_ready=0, in_valid pulses not accepted. Raise out_ready -> out_valid=0 and in_ready=1 on the next cycle.
- Reset mid-op: assert rst at T+4 of a MULL -> next cycle out_valid=0, in_ready=1, q=0, z=1. A subsequent ADD 0x01+0x01 -> q=0x02 at T'+1.

Source files
------------

// File: rtl/iter_alu.sv
// iter_alu: clocked ALU with a valid/ready operand handshake and a registered
// result. Logic/arithmetic ops finish in one cycle. Shifts, rotates and the
// unsigned multiply iterate one bit per cycle.
module iter_alu #(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic             cout,
  output logic             z
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  typedef enum logic [3:0] {
    OP_AND  = 4'd0,
    OP_OR   = 4'd1,
    OP_XOR  = 4'd2,
    OP_NOT  = 4'd3,
    OP_ADD  = 4'd4,
    OP_ADC  = 4'd5,
    OP_SUB  = 4'd6,
    OP_SBC  = 4'd7,
    OP_SHL  = 4'd8,
    OP_SHR  = 4'd9,
    OP_SAR  = 4'd10,
    OP_ROL  = 4'd11,
    OP_MULL = 4'd12,
    OP_MULH = 4'd13,
    OP_RS14 = 4'd14,
    OP_RS15 = 4'd15
  } op_t;

  localparam logic [SHW:0] CNT_ONE   = (SHW+1)'(1);
  localparam logic [SHW:0] CNT_WIDTH = (SHW+1)'(WIDTH);

  state_t             state_q;
  op_t                op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   sh_q;
  logic               carry_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [SHW:0]       cnt_q;
  logic               out_valid_q;
  logic [WIDTH-1:0]   q_q;
  logic               cout_q;

  op_t                op_in;
  logic [WIDTH-1:0]   alu_q;
  logic               alu_c;
  logic [WIDTH-1:0]   sh_nx;
  logic               sh_c;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] acc_nx;
  logic [SHW:0]       cnt_in;

  assign op_in  = op_t'(op);
  assign cnt_in = {1'b0, b[SHW-1:0]};

  // Single-cycle result, computed straight from the live inputs at accept
  always_comb begin
    logic [WIDTH:0] sum;
    logic [WIDTH-1:0] bb;
    logic c;
    bb    = b;
    c     = 1'b0;
    alu_q = '0;
    alu_c = 1'b0;
    case (op_in)
      OP_ADC: c = cin;
      OP_SUB: begin bb = ~b; c = 1'b1; end
      OP_SBC: begin bb = ~b; c = cin;  end
      default: ;
    endcase
    sum = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, c};
    case (op_in)
      OP_AND: alu_q = a & b;
      OP_OR:  alu_q = a | b;
      OP_XOR: alu_q = a ^ b;
      OP_NOT: alu_q = ~a;
      OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
        alu_q = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
      end
      default: ;
    endcase
  end

  // One bit of shift/rotate, with the bit that leaves the word
  always_comb begin
    sh_nx = sh_q;
    sh_c  = carry_q;
    case (op_q)
      OP_SHL: begin sh_nx = {sh_q[WIDTH-2:0], 1'b0};          sh_c = sh_q[WIDTH-1]; end
      OP_SHR: begin sh_nx = {1'b0, sh_q[WIDTH-1:1]};          sh_c = sh_q[0];       end
      OP_SAR: begin sh_nx = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]}; sh_c = sh_q[0];       end
      OP_ROL: begin sh_nx = {sh_q[WIDTH-2:0], sh_q[WIDTH-1]}; sh_c = sh_q[WIDTH-1]; end
      default: ;
    endcase
  end

  // Shift-add step: the multiplier sits in the low half and is consumed LSB
  // first while the partial sum (with its carry) shifts in from the top
  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? a_q : '0)};
    acc_nx  = {mul_sum, acc_q[WIDTH-1:1]};
  end

  // Control FSM with registered result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_AND;
      a_q         <= '0;
      sh_q        <= '0;
      carry_q     <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      q_q         <= '0;
      cout_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_q <= op_in;
            a_q  <= a;
            case (op_in)
              OP_SHL, OP_SHR, OP_SAR, OP_ROL: begin
                if (cnt_in == '0) begin
                  q_q         <= a;
                  cout_q      <= cin;
                  out_valid_q <= 1'b1;
                  state_q     <= S_DONE;
                end else begin
                  sh_q    <= a;
                  carry_q <= cin;
                  cnt_q   <= cnt_in;
                  state_q <= S_BUSY;
                end
              end
              OP_MULL, OP_MULH: begin
                acc_q   <= {{WIDTH{1'b0}}, b};
                cnt_q   <= CNT_WIDTH;
                state_q <= S_BUSY;
              end
              default: begin
                q_q         <= alu_q;
                cout_q      <= alu_c;
                out_valid_q <= 1'b1;
                state_q     <= S_DONE;
              end
            endcase
          end
        end
        S_BUSY: begin
          cnt_q <= cnt_q - CNT_ONE;
          if (op_q == OP_MULL || op_q == OP_MULH) begin
            acc_q <= acc_nx;
            if (cnt_q == CNT_ONE) begin
              if (op_q == OP_MULH) begin
                q_q    <= acc_nx[2*WIDTH-1:WIDTH];
                cout_q <= 1'b0;
              end else begin
                q_q    <= acc_nx[WIDTH-1:0];
                cout_q <= |acc_nx[2*WIDTH-1:WIDTH];
              end
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end
          end else begin
            sh_q    <= sh_nx;
            carry_q <= sh_c;
            if (cnt_q == CNT_ONE) begin
              q_q         <= sh_nx;
              cout_q      <= sh_c;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign q         = q_q;
  assign cout      = cout_q;
  assign z         = (q_q == '0);

endmodule

// File: tb/tb_iter_alu.sv
// Bench for iter_alu (WIDTH=8): vector table through a scoreboard queue, plus
// hand sequences for backpressure and reset during a multiply.
module tb_iter_alu;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] op;
  logic       cin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] q;
  logic       cout;
  logic       z;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    logic [3:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        cin;
    logic [7:0]  eq;
    logic        ec;
    int unsigned lat;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  iter_alu #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .cin(cin), .out_valid(out_valid),
    .out_ready(out_ready), .q(q), .cout(cout), .z(z)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] o, input logic [7:0] va, input logic [7:0] vb,
                              input logic vc, input logic [7:0] eq, input logic ec,
                              input int unsigned lat);
    vec_t v;
    v.op = o; v.a = va; v.b = vb; v.cin = vc; v.eq = eq; v.ec = ec; v.lat = lat;
    return v;
  endfunction

  // Drive one op, scoreboard it, wait for the result, compare, then hand it off
  task automatic run_op(input vec_t v, input string nm);
    int unsigned lat;
    vec_t e;
    lat = 0;
    while (!in_ready && lat < 50) begin @(posedge clk); #1; lat++; end
    check({nm, " in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; a = v.a; b = v.b; op = v.op; cin = v.cin;
    @(posedge clk);
    sb.push_back(v);
    #1;
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); op = 4'($urandom); cin = 1'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    check({nm, " latency"}, lat, v.lat);
    if (out_valid && sb.size() != 0) begin
      e = sb.pop_front();
      check({nm, " q"}, 32'(q), 32'(e.eq));
      check({nm, " cout"}, 32'(cout), 32'(e.ec));
      check({nm, " z"}, 32'(z), 32'(e.eq == 8'h00));
    end else begin
      sb.delete();
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({nm, " out_valid drop"}, 32'(out_valid), 32'd0);
    check({nm, " in_ready back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [7:0] hq;
    logic       hc;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; op = '0; cin = 1'b0;

    //            op     a      b      cin   q      cout lat
    vecs.push_back(mk(4'd4,  8'hF0, 8'h20, 1'b1, 8'h10, 1'b1, 1));
    vecs.push_back(mk(4'd5,  8'hF0, 8'h20, 1'b1, 8'h11, 1'b1, 1));
    vecs.push_back(mk(4'd6,  8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1));
    vecs.push_back(mk(4'd7,  8'h05, 8'h05, 1'b0, 8'hFF, 1'b0, 1));
    vecs.push_back(mk(4'd6,  8'h33, 8'h33, 1'b0, 8'h00, 1'b1, 1));
    vecs.push_back(mk(4'd0,  8'hF0, 8'h3C, 1'b1, 8'h30, 1'b0, 1));
    vecs.push_back(mk(4'd1,  8'hF0, 8'h0F, 1'b0, 8'hFF, 1'b0, 1));
    vecs.push_back(mk(4'd2,  8'hFF, 8'h0F, 1'b0, 8'hF0, 1'b0, 1));
    vecs.push_back(mk(4'd3,  8'h5A, 8'h00, 1'b1, 8'hA5, 1'b0, 1));
    vecs.push_back(mk(4'd9,  8'h81, 8'h03, 1'b0, 8'h10, 1'b0, 4));
    vecs.push_back(mk(4'd10, 8'h80, 8'h02, 1'b0, 8'hE0, 1'b0, 3));
    vecs.push_back(mk(4'd11, 8'h81, 8'h01, 1'b0, 8'h03, 1'b1, 2));
    vecs.push_back(mk(4'd8,  8'h5A, 8'h00, 1'b1, 8'h5A, 1'b1, 1));
    vecs.push_back(mk(4'd8,  8'hC3, 8'h01, 1'b0, 8'h86, 1'b1, 2));
    vecs.push_back(mk(4'd8,  8'hC3, 8'h09, 1'b0, 8'h86, 1'b1, 2));
    vecs.push_back(mk(4'd8,  8'h01, 8'h07, 1'b1, 8'h80, 1'b0, 8));
    vecs.push_back(mk(4'd9,  8'h80, 8'h07, 1'b1, 8'h01, 1'b0, 8));
    vecs.push_back(mk(4'd11, 8'h81, 8'h04, 1'b1, 8'h18, 1'b0, 5));
    vecs.push_back(mk(4'd10, 8'h7F, 8'h07, 1'b0, 8'h00, 1'b1, 8));
    vecs.push_back(mk(4'd12, 8'h12, 8'h34, 1'b0, 8'hA8, 1'b1, 9));
    vecs.push_back(mk(4'd13, 8'h12, 8'h34, 1'b1, 8'h03, 1'b0, 9));
    vecs.push_back(mk(4'd12, 8'hFF, 8'h01, 1'b0, 8'hFF, 1'b0, 9));
    vecs.push_back(mk(4'd12, 8'hFF, 8'hFF, 1'b0, 8'h01, 1'b1, 9));
    vecs.push_back(mk(4'd13, 8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b0, 9));
    vecs.push_back(mk(4'd14, 8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0, 1));
    vecs.push_back(mk(4'd15, 8'h12, 8'h34, 1'b1, 8'h00, 1'b0, 1));

    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset q", 32'(q), 32'd0);
    check("reset cout", 32'(cout), 32'd0);
    check("reset z", 32'(z), 32'd1);

    for (int i = 0; i < vecs.size(); i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: hold the ADD result while offering ops that must be ignored
    in_valid = 1'b1; a = 8'hF0; b = 8'h20; op = 4'd4; cin = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    hq = 8'h10; hc = 1'b1;
    check("bp out_valid", 32'(out_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      in_valid = k[0]; a = 8'h0F; b = 8'h0F; op = 4'd2; cin = 1'b0;
      @(posedge clk); #1;
      check($sformatf("bp%0d q", k), 32'(q), 32'(hq));
      check($sformatf("bp%0d cout", k), 32'(cout), 32'(hc));
      check($sformatf("bp%0d in_ready", k), 32'(in_ready), 32'd0);
      check($sformatf("bp%0d out_valid", k), 32'(out_valid), 32'd1);
    end
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    check("bp release out_valid", 32'(out_valid), 32'd0);
    check("bp release in_ready", 32'(in_ready), 32'd1);
    check("bp held q", 32'(q), 32'(hq));
    check("bp held cout", 32'(cout), 32'(hc));

    // Reset during a multiply: rst high at the fourth edge after accept
    in_valid = 1'b1; a = 8'h12; b = 8'h34; op = 4'd12; cin = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid mul busy", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst mid out_valid", 32'(out_valid), 32'd0);
    check("rst mid in_ready", 32'(in_ready), 32'd1);
    check("rst mid q", 32'(q), 32'd0);
    check("rst mid z", 32'(z), 32'd1);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check($sformatf("rst abandon%0d", k), 32'(out_valid), 32'd0);
    end
    run_op(mk(4'd4, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1), "post-rst add");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
